// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event path.
// Holds the scan-code prefixes, the non-key response bytes, the parse states and the event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StGotE0,
        StGotF0,
        StGotE0F0
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Keyboard status/response bytes that never form part of a key event.
    function automatic logic is_response(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// A push into a full FIFO succeeds only when a pop happens in the same cycle; otherwise it is dropped.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, not_full_q;
    logic             full, pop_ok, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);
    // The same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            not_full_q <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            not_full_q <= (count_d != CW'(DEPTH));
        end
    end

    assign valid    = valid_q;
    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign not_full = not_full_q;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Parses PS/2 scan-code bytes into {ext, brk, code} events and queues them for the CPU I/O module.
// Define PS2_PREFIX_TIMEOUT_EN to abandon a prefix sequence after TIMEOUT_CYC idle cycles.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [7:0]             dout,
    output logic                   rx_en,
    input  logic                   ev_rd,
    output logic                   ev_valid,
    output logic [9:0]             ev_data,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   ovf,
    output logic                   proto_err,
    input  logic                   clr_flags
);

    ps2_state_e state_q, state_d;
    ps2_event_t push_ev;
    logic       push, perr_set, drop;
    logic       ovf_q, ovf_d, perr_q, perr_d;
    logic [9:0] head;

`ifdef PS2_PREFIX_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        timeout;

    assign timeout = (state_q != StIdle) && (tmo_q >= TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (reset || (state_q == StIdle) || rx_done_tick) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_ev  = '0;
        perr_set = 1'b0;
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (dout == PS2_EXT) begin
                        state_d = StGotE0;
                    end else if (dout == PS2_BRK) begin
                        state_d = StGotF0;
                    end else if (!is_response(dout)) begin
                        push    = 1'b1;
                        push_ev = '{ext: 1'b0, brk: 1'b0, code: dout};
                    end
                end
                StGotE0: begin
                    if (dout == PS2_BRK) begin
                        state_d = StGotE0F0;
                    end else if (dout != PS2_EXT) begin
                        push    = 1'b1;
                        push_ev = '{ext: 1'b1, brk: 1'b0, code: dout};
                        state_d = StIdle;
                    end
                end
                StGotF0, StGotE0F0: begin
                    state_d = StIdle;
                    if ((dout == PS2_EXT) || (dout == PS2_BRK)) begin
                        perr_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        push_ev = '{ext: (state_q == StGotE0F0), brk: 1'b1, code: dout};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef PS2_PREFIX_TIMEOUT_EN
        else if (timeout) begin
            state_d  = StIdle;
            perr_set = 1'b1;
        end
`endif
    end

    // A flag being set in the same cycle as clr_flags stays set.
    always_comb begin
        ovf_d  = clr_flags ? 1'b0 : ovf_q;
        perr_d = clr_flags ? 1'b0 : perr_q;
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (perr_set) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_rd),
        .valid     (ev_valid),
        .head      (head),
        .count     (ev_count),
        .not_full  (rx_en),
        .drop      (drop)
    );

    assign ev_data   = head;
    assign ovf       = ovf_q;
    assign proto_err = perr_q;

endmodule
